// File: rtl/seven_seg_capture.sv
// -----------------------------------------------------------------------------
// seven_seg_capture
//
// Receive side of a multiplexed 7-segment bus (7 active-low segments plus one
// digit-select line). The bus is synchronised into clk. Each digit pattern must
// hold steady for a while before it is accepted. Accepted patterns are decoded
// back to hex nibbles, and the two digits are assembled into one 8-bit value.
// Typical uses are loopback self-check of a display path and reading a
// stopwatch display driven from another tile.
//
// Parameters
//   STABLE_CYCLES  : synced bus must hold unchanged this many cycles before a
//                    digit is accepted (>= 1)
//   TIMEOUT_CYCLES : cycles without an accepted digit before stale asserts (>= 2)
//
// Ports
//   clk          in   clock
//   rst_n        in   asynchronous active-low reset
//   seg_n[6:0]   in   segments a..g (bit0 = a), active low, asynchronous
//   dig_sel      in   0 = MSB digit on the bus, 1 = LSB digit on the bus, asynchronous
//   clear        in   synchronous clear of the capture state, active high
//   value[7:0]   out  last good frame {msb_nibble, lsb_nibble}
//   value_valid  out  one-cycle pulse when value is updated
//   digit_err    out  one-cycle pulse when a frame completes with an undecodable digit
//   stale        out  level; no digit has been accepted for TIMEOUT_CYCLES cycles
// -----------------------------------------------------------------------------
module seven_seg_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_n,
    input  logic       dig_sel,
    input  logic       clear,
    output logic [7:0] value,
    output logic       value_valid,
    output logic       digit_err,
    output logic       stale
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_HIT = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_ONE = STAB_W'(1);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]   TO_ONE   = TO_W'(1);

    // Active-high segment patterns for hex digits 0..F.
    // The entry for digit n sits at bits [n*7 +: 7].
    localparam logic [16*7-1:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HAVE_MSB = 2'd1,
        ST_HAVE_LSB = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchroniser and stability tracking
    // ------------------------------------------------------------------
    logic [7:0]        sync_meta_reg;
    logic [7:0]        sb_reg;          // synced bus {dig_sel, seg_n}
    logic [7:0]        sb_prev_reg;     // synced bus one cycle earlier
    logic [STAB_W-1:0] stab_cnt_reg;
    logic              armed_reg;

    logic              sb_changed;
    logic [6:0]        pat;
    logic              sel;
    logic              accept;

    assign sb_changed = (sb_reg != sb_prev_reg);
    assign pat        = ~sb_reg[6:0];
    assign sel        = sb_reg[7];

    // A pattern is taken once, on the cycle where it has been steady long
    // enough. armed prevents a long-held pattern from being taken again.
    // A blank bus is never taken.
    assign accept = !sb_changed && (stab_cnt_reg == STAB_HIT) && armed_reg && (pat != 7'h00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_reg <= 8'hFF;
            sb_reg        <= 8'hFF;
            sb_prev_reg   <= 8'hFF;
            stab_cnt_reg  <= '0;
            armed_reg     <= 1'b1;
        end else begin
            sync_meta_reg <= {dig_sel, seg_n};
            sb_reg        <= sync_meta_reg;
            sb_prev_reg   <= sb_reg;

            if (sb_changed) begin
                stab_cnt_reg <= '0;
            end else if (stab_cnt_reg != STAB_MAX) begin
                stab_cnt_reg <= stab_cnt_reg + STAB_ONE;
            end

            // clear re-arms even if an accept happens in the same cycle.
            if (clear || sb_changed) begin
                armed_reg <= 1'b1;
            end else if (accept) begin
                armed_reg <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pattern decode: one comparator per hex digit, then encode the hit
    // ------------------------------------------------------------------
    logic [15:0] dec_hit;
    logic [3:0]  dec_nib;
    logic        dec_bad;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_dec
            assign dec_hit[gi] = (pat == SEG_TABLE[gi*7 +: 7]);
        end
    endgenerate

    always_comb begin
        dec_nib = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (dec_hit[i]) begin
                dec_nib = 4'(i);
            end
        end
    end

    // An unknown pattern decodes as nibble 0 and is flagged as bad.
    assign dec_bad = ~|dec_hit;

    // ------------------------------------------------------------------
    // Frame assembly, timeout and registered outputs
    // ------------------------------------------------------------------
    state_t          state_reg;
    logic [3:0]      msb_reg;
    logic [3:0]      lsb_reg;
    logic            msb_bad_reg;
    logic            lsb_bad_reg;
    logic [7:0]      value_reg;
    logic            value_valid_reg;
    logic            digit_err_reg;
    logic [TO_W-1:0] to_cnt_reg;
    logic            stale_reg;

    logic            frame_done;
    logic            frame_bad;
    logic [7:0]      frame_value;
    logic [TO_W-1:0] to_cnt_next;

    // A frame completes when the opposite digit of the one already held is
    // accepted. The digit already held supplies one nibble and the new
    // digit supplies the other.
    always_comb begin
        frame_done  = 1'b0;
        frame_bad   = 1'b0;
        frame_value = 8'h00;
        case (state_reg)
            ST_HAVE_MSB: begin
                frame_done  = accept && sel;
                frame_bad   = msb_bad_reg | dec_bad;
                frame_value = {msb_reg, dec_nib};
            end
            ST_HAVE_LSB: begin
                frame_done  = accept && !sel;
                frame_bad   = lsb_bad_reg | dec_bad;
                frame_value = {dec_nib, lsb_reg};
            end
            default: begin
                frame_done  = 1'b0;
                frame_bad   = 1'b0;
                frame_value = 8'h00;
            end
        endcase
    end

    // The counter drops to zero on an accept, so stale also falls on that
    // same cycle.
    always_comb begin
        to_cnt_next = to_cnt_reg;
        if (clear || accept) begin
            to_cnt_next = '0;
        end else if (to_cnt_reg != TO_MAX) begin
            to_cnt_next = to_cnt_reg + TO_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            msb_reg         <= 4'h0;
            lsb_reg         <= 4'h0;
            msb_bad_reg     <= 1'b0;
            lsb_bad_reg     <= 1'b0;
            value_reg       <= 8'h00;
            value_valid_reg <= 1'b0;
            digit_err_reg   <= 1'b0;
            to_cnt_reg      <= '0;
            stale_reg       <= 1'b0;
        end else begin
            value_valid_reg <= 1'b0;
            digit_err_reg   <= 1'b0;
            to_cnt_reg      <= to_cnt_next;
            stale_reg       <= (to_cnt_next == TO_MAX);

            if (clear) begin
                state_reg   <= ST_IDLE;
                msb_reg     <= 4'h0;
                lsb_reg     <= 4'h0;
                msb_bad_reg <= 1'b0;
                lsb_bad_reg <= 1'b0;
                value_reg   <= 8'h00;
            end else if (frame_done) begin
                if (frame_bad) begin
                    digit_err_reg <= 1'b1;
                end else begin
                    value_reg       <= frame_value;
                    value_valid_reg <= 1'b1;
                end
                state_reg   <= ST_IDLE;
                msb_bad_reg <= 1'b0;
                lsb_bad_reg <= 1'b0;
            end else if (accept) begin
                if (!sel) begin
                    msb_reg     <= dec_nib;
                    msb_bad_reg <= dec_bad;
                    if (state_reg == ST_IDLE) begin
                        state_reg <= ST_HAVE_MSB;
                    end
                end else begin
                    lsb_reg     <= dec_nib;
                    lsb_bad_reg <= dec_bad;
                    if (state_reg == ST_IDLE) begin
                        state_reg <= ST_HAVE_LSB;
                    end
                end
            end
        end
    end

    assign value       = value_reg;
    assign value_valid = value_valid_reg;
    assign digit_err   = digit_err_reg;
    assign stale       = stale_reg;

endmodule

// File: tb/tb_seven_seg_capture.sv
// -----------------------------------------------------------------------------
// tb_seven_seg_capture
//
// Directed bench for seven_seg_capture using the default parameters
// (STABLE_CYCLES = 4, TIMEOUT_CYCLES = 4096). Expected values are worked out by
// hand. The bus is driven 1 ns after a rising edge, so the first edge that
// sees a new value is edge 1 of the window that follows.
// -----------------------------------------------------------------------------
module tb_seven_seg_capture;

    localparam int STABLE_CYCLES  = 4;
    localparam int TIMEOUT_CYCLES = 4096;
    localparam int LATENCY        = 2 + STABLE_CYCLES + 1;

    logic       clk;
    logic       rst_n;
    logic [6:0] seg_n;
    logic       dig_sel;
    logic       clear;
    logic [7:0] value;
    logic       value_valid;
    logic       digit_err;
    logic       stale;

    seven_seg_capture #(
        .STABLE_CYCLES  (STABLE_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .dig_sel     (dig_sel),
        .clear       (clear),
        .value       (value),
        .value_valid (value_valid),
        .digit_err   (digit_err),
        .stale       (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low segment codes for the decimal digits 0..9
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int         checks   = 0;
    int         failures = 0;

    // Observations collected over a window of clock edges
    int         n_valid;
    int         n_err;
    int         n_stale;
    int         first_valid;
    int         first_err;
    logic [7:0] last_value;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] s, input logic d);
        seg_n   = s;
        dig_sel = d;
    endtask

    task automatic clear_watch();
        n_valid     = 0;
        n_err       = 0;
        n_stale     = 0;
        first_valid = 0;
        first_err   = 0;
        last_value  = 8'h00;
    endtask

    // Runs n clock edges and samples the outputs 1 ns after each edge.
    task automatic run_watch(input int n);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (value_valid) begin
                n_valid++;
                if (first_valid == 0) first_valid = i;
                last_value = value;
            end
            if (digit_err) begin
                n_err++;
                if (first_err == 0) first_err = i;
            end
            if (stale) n_stale++;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        clear   = 1'b0;
        seg_n   = 7'h7F;
        dig_sel = 1'b1;
        clear_watch();

        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        #1;
        chk("reset_value", value, 8'h00);
        chk("reset_valid", value_valid, 1'b0);
        chk("reset_err", digit_err, 1'b0);
        chk("reset_stale", stale, 1'b0);
        rst_n = 1'b1;

        // ---------------- 1) basic frame, exact latency ----------------
        drive(7'h19, 1'b0);                 // 4 as the MSB
        run_watch(20);
        chk("t1_no_early_valid", n_valid, 0);
        clear_watch();
        drive(7'h24, 1'b1);                 // 2 as the LSB
        run_watch(15);
        chk("t1_valid_latency", first_valid, LATENCY);
        chk("t1_valid_count", n_valid, 1);
        chk("t1_value", last_value, 8'h42);
        chk("t1_no_err", n_err, 0);

        // ---------------- 2) stopwatch mux 00..99 ----------------
        clear_watch();
        for (int c = 0; c < 100; c++) begin
            int         tens;
            int         ones;
            logic [7:0] exp_val;
            int         v_before;
            tens     = c / 10;
            ones     = c % 10;
            exp_val  = {4'(tens), 4'(ones)};
            v_before = n_valid;
            drive(seg_tab[tens], 1'b0);
            run_watch(64);
            drive(seg_tab[ones], 1'b1);
            run_watch(64);
            chk("t2_frame_count", n_valid - v_before, 1);
            chk("t2_value", last_value, exp_val);
        end
        chk("t2_no_err", n_err, 0);
        chk("t2_no_stale", n_stale, 0);
        chk("t2_final_value", value, 8'h99);

        // ---------------- 3) glitch filtering ----------------
        clear_watch();
        for (int k = 0; k < 10; k++) begin
            drive((k % 2 == 0) ? 7'h79 : 7'h24, 1'b0);
            run_watch(2);
        end
        drive(7'h40, 1'b0);                 // settle on 0 as the MSB
        run_watch(20);
        for (int k = 0; k < 10; k++) begin
            drive((k % 2 == 0) ? 7'h79 : 7'h24, 1'b1);
            run_watch(2);
        end
        chk("t3_no_accept_while_glitching", n_valid + n_err, 0);
        clear_watch();
        drive(7'h78, 1'b1);                 // settle on 7 as the LSB
        run_watch(15);
        chk("t3_valid_count", n_valid, 1);
        chk("t3_valid_latency", first_valid, LATENCY);
        chk("t3_value", last_value, 8'h07);

        // ---------------- 4) undecodable digit ----------------
        clear_watch();
        drive(7'h00, 1'b0);                 // 8 as the MSB
        run_watch(20);
        drive(7'h2A, 1'b1);                 // pattern 0x55, not a hex digit
        run_watch(15);
        chk("t4_err_count", n_err, 1);
        chk("t4_no_valid", n_valid, 0);
        chk("t4_value_held", value, 8'h07);
        clear_watch();
        drive(7'h30, 1'b1);                 // LSB first: 3
        run_watch(20);
        drive(7'h12, 1'b0);                 // then MSB: 5
        run_watch(20);
        chk("t4_idle_after_err_count", n_valid, 1);
        chk("t4_idle_after_err_value", last_value, 8'h53);
        chk("t4_idle_after_err_noerr", n_err, 0);

        // ---------------- 5) timeout on a blank bus ----------------
        clear_watch();
        drive(7'h7F, 1'b0);
        run_watch(4000);
        chk("t5_not_yet_stale", stale, 1'b0);
        run_watch(TIMEOUT_CYCLES + 5 - 4000);
        chk("t5_stale", stale, 1'b1);
        chk("t5_no_valid", n_valid, 0);
        chk("t5_no_err", n_err, 0);
        clear_watch();
        drive(7'h79, 1'b0);                 // 1 as the MSB
        run_watch(LATENCY - 1);
        chk("t5_stale_before_accept", stale, 1'b1);
        run_watch(1);
        chk("t5_stale_drops_on_accept", stale, 1'b0);
        run_watch(13);
        drive(7'h02, 1'b1);                 // 6 as the LSB
        run_watch(15);
        chk("t5_value", last_value, 8'h16);
        chk("t5_valid_count", n_valid, 1);

        // ---------------- 6) clear and asynchronous reset ----------------
        clear_watch();
        drive(7'h30, 1'b0);                 // 3 as the MSB, accepted
        run_watch(20);
        clear = 1'b1;
        run_watch(1);
        clear = 1'b0;
        chk("t6_clear_value", value, 8'h00);
        drive(7'h12, 1'b1);                 // 5 as the LSB only
        run_watch(20);
        chk("t6_no_frame_after_clear", n_valid + n_err, 0);
        drive(7'h10, 1'b0);                 // 9 as the MSB
        run_watch(20);
        chk("t6_value", last_value, 8'h95);
        chk("t6_valid_count", n_valid, 1);

        clear_watch();
        drive(7'h24, 1'b0);                 // 2 as the MSB, accepted
        run_watch(20);
        #2;
        rst_n = 1'b0;                       // between clock edges
        #1;
        chk("t6_async_reset_value", value, 8'h00);
        chk("t6_async_reset_stale", stale, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive(7'h19, 1'b1);                 // 4 as the LSB; the MSB was lost
        run_watch(20);
        chk("t6_no_partial_frame", n_valid + n_err, 0);
        chk("t6_value_after_reset", value, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
